fetch_prefetch_buffer: RTL

//  Sequential instruction-byte prefetcher between the combinational program ROM
//  (12-bit addr, 8-bit data, same-cycle read) and the CPU core fetch stage.

---
 rtl/fetch_prefetch_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction-byte prefetcher: walks the ROM address, buffers {byte, addr}
// pairs in a small FIFO for the core, and flushes/refetches on a redirect.
module fetch_prefetch_buffer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [DATA_W-1:0]          rom_data_i,
    input  logic                       redir_valid_i,
    input  logic [ADDR_W-1:0]          redir_addr_i,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic [DATA_W-1:0]          byte_data_o,
    output logic [ADDR_W-1:0]          byte_addr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fptr_q, fptr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic              push_s;
    logic              pop_s;

    assign rom_addr_o   = fptr_q;
    assign byte_valid_o = (cnt_q != {CNT_W{1'b0}});
    assign byte_data_o  = mem_data_q[rd_q];
    assign byte_addr_o  = mem_addr_q[rd_q];
    assign count_o      = cnt_q;

    // Handshake qualification and next-state pointers; a redirect cancels both push and pop.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        fptr_d = fptr_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        if (redir_valid_i) begin
            fptr_d = redir_addr_i;
            rd_d   = {PTR_W{1'b0}};
            wr_d   = {PTR_W{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
        end else begin
            pop_s  = byte_valid_o & byte_ready_i;
            // A full FIFO can still accept a byte when the head leaves in the same cycle.
            push_s = (cnt_q < CNT_W'(DEPTH)) | pop_s;
            if (push_s) begin
                fptr_d = fptr_q + ADDR_W'(1);
                wr_d   = wr_q + PTR_W'(1);
            end else begin
                fptr_d = fptr_q;
                wr_d   = wr_q;
            end
            if (pop_s) begin
                rd_d = rd_q + PTR_W'(1);
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer, occupancy and fetch-address registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fptr_q <= RESET_PC;
            rd_q   <= {PTR_W{1'b0}};
            wr_q   <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            fptr_q <= fptr_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= {DATA_W{1'b0}};
                mem_addr_q[i] <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            mem_data_q[wr_q] <= rom_data_i;
            mem_addr_q[wr_q] <= fptr_q;
        end else begin
            mem_data_q[wr_q] <= mem_data_q[wr_q];
            mem_addr_q[wr_q] <= mem_addr_q[wr_q];
        end
    end

endmodule
